// File: rtl/uart_sys_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_sys_pkg
// Description : Shared definitions for the UART command-frame controller.
//               Provides the one-hot controller state encoding, the default
//               command opcodes and the default data/address widths.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_sys_pkg;

  // Default widths for the command controller datapath.
  localparam int unsigned c_DATA_WIDTH = 8;
  localparam int unsigned c_ADDR_WIDTH = 4;

  // Default command opcodes carried in the first byte of a frame.
  localparam logic [7:0] c_CMD_WR = 8'hAA;
  localparam logic [7:0] c_CMD_RD = 8'hBB;

  // One-hot controller states.
  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_WR_ADDR = 6'b000010,
    ST_WR_DATA = 6'b000100,
    ST_RD_ADDR = 6'b001000,
    ST_RD_WAIT = 6'b010000,
    ST_TX_SEND = 6'b100000
  } ctrl_state_e;

  // States in which the controller is waiting on further serial bytes of a
  // frame; only these are guarded by the inter-byte timeout.
  function automatic logic is_frame_state(input ctrl_state_e s);
    return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR);
  endfunction

endpackage : uart_sys_pkg
`default_nettype wire

// File: rtl/uart_frame_timeout.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_timeout
// Description : Inter-byte watchdog for the command controller. Counts clock
//               cycles while enabled, restarts from zero on every clear, and
//               flags expiry on the edge where the count reaches
//               TIMEOUT_CYC-1.
// Revision    : 1.0 - initial release
//
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   en     in   counting enable (controller is inside a frame)
//   clr    in   restart the count (a byte or error event was seen)
//   expire out  combinational: the count reaches TIMEOUT_CYC-1 on this edge
// ============================================================================
module uart_frame_timeout #(
  parameter int TIMEOUT_CYC = 1024   // must be >= 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int c_CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 2;
  localparam logic [c_CW-1:0] c_LAST     = c_CW'(TIMEOUT_CYC - 1);
  localparam logic [c_CW-1:0] c_PRE_LAST = c_CW'(TIMEOUT_CYC - 2);

  logic [c_CW-1:0] r_cnt;

  // The count is 0 in the first cycle after an event, so it holds
  // TIMEOUT_CYC-1 in the same cycle that the registered abort becomes
  // visible. Expiry is therefore flagged one count early, combinationally,
  // so the controller can register the abort on that edge.
  assign expire = en & ~clr & (r_cnt == c_PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!en || clr) begin
      r_cnt <= '0;
    end else if (r_cnt != c_LAST) begin
      r_cnt <= r_cnt + c_CW'(1);
    end
  end

endmodule : uart_frame_timeout
`default_nettype wire

// File: rtl/uart_rx_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_cmd_ctrl
// Description : Command-frame controller between the UART receiver and the
//               register file. Decodes write frames (CMD_WR, addr, data) and
//               read frames (CMD_RD, addr), strobes the register file, and
//               returns read data to the UART transmitter. Malformed frames,
//               receive errors and inter-byte timeouts abort the frame,
//               pulse CMD_ERR and bump a saturating error counter.
// Revision    : 1.0 - initial release
//
// Ports
//   CLK         in   system clock
//   RST         in   asynchronous active-low reset
//   RX_P_DATA   in   received byte
//   RX_D_VLD    in   received byte valid pulse
//   RX_PAR_ERR  in   parity error pulse for the current byte
//   RX_STP_ERR  in   stop-bit error pulse for the current byte
//   RF_WR_EN    out  one-cycle register write strobe
//   RF_RD_EN    out  one-cycle register read strobe
//   RF_ADDR     out  register address (holds last accepted address)
//   RF_WR_DATA  out  register write data (holds last written data)
//   RF_RD_DATA  in   register read data
//   RF_RD_VLD   in   register read data valid pulse
//   TX_P_DATA   out  byte to transmit (holds until the next read completes)
//   TX_D_VLD    out  one-cycle transmit request
//   TX_BUSY     in   transmitter busy
//   CMD_ERR     out  one-cycle pulse on every abort
//   ERR_CNT     out  saturating abort count
// ============================================================================
module uart_rx_cmd_ctrl
  import uart_sys_pkg::*;
#(
  parameter int                    DATA_WIDTH  = c_DATA_WIDTH,
  parameter int                    ADDR_WIDTH  = c_ADDR_WIDTH,
  parameter int                    TIMEOUT_CYC = 1024,
  parameter logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(c_CMD_WR),
  parameter logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(c_CMD_RD)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_PAR_ERR,
  input  logic                  RX_STP_ERR,
  output logic                  RF_WR_EN,
  output logic                  RF_RD_EN,
  output logic [ADDR_WIDTH-1:0] RF_ADDR,
  output logic [DATA_WIDTH-1:0] RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0] RF_RD_DATA,
  input  logic                  RF_RD_VLD,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY,
  output logic                  CMD_ERR,
  output logic [7:0]            ERR_CNT
);

  ctrl_state_e r_state;

  logic w_err_ev;
  logic w_byte_ev;
  logic w_any_ev;
  logic w_addr_ok;
  logic w_tmo_en;
  logic w_expire;
  logic w_abort;

  // A receive error wins over a simultaneous valid strobe: the byte is
  // treated as corrupt and never decoded.
  assign w_err_ev  = RX_PAR_ERR | RX_STP_ERR;
  assign w_byte_ev = RX_D_VLD & ~w_err_ev;
  assign w_any_ev  = w_byte_ev | w_err_ev;

  // Address bytes must not set any bit above the register-file range.
  generate
    if (ADDR_WIDTH < DATA_WIDTH) begin : g_addr_hi_chk
      assign w_addr_ok = ~|RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH];
    end else begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end
  endgenerate

  assign w_tmo_en = is_frame_state(r_state);

  uart_frame_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (CLK),
    .rst_n  (RST),
    .en     (w_tmo_en),
    .clr    (w_any_ev),
    .expire (w_expire)
  );

  // Abort decision for the current cycle. In RD_WAIT/TX_SEND any incoming
  // byte or error is counted as an abort but the pending read is kept.
  always_comb begin
    w_abort = 1'b0;
    case (r_state)
      ST_IDLE:
        w_abort = w_err_ev |
                  (w_byte_ev & (RX_P_DATA != CMD_WR) & (RX_P_DATA != CMD_RD));
      ST_WR_ADDR,
      ST_RD_ADDR:
        w_abort = w_err_ev | (w_byte_ev & ~w_addr_ok) | w_expire;
      ST_WR_DATA:
        w_abort = w_err_ev | w_expire;
      ST_RD_WAIT,
      ST_TX_SEND:
        w_abort = w_any_ev;
      default:
        w_abort = 1'b0;
    endcase
  end

  // Controller FSM with registered strobes and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      RF_WR_EN   <= 1'b0;
      RF_RD_EN   <= 1'b0;
      RF_ADDR    <= '0;
      RF_WR_DATA <= '0;
      TX_P_DATA  <= '0;
      TX_D_VLD   <= 1'b0;
    end else begin
      RF_WR_EN <= 1'b0;
      RF_RD_EN <= 1'b0;
      TX_D_VLD <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_byte_ev) begin
            if (RX_P_DATA == CMD_WR) begin
              r_state <= ST_WR_ADDR;
            end else if (RX_P_DATA == CMD_RD) begin
              r_state <= ST_RD_ADDR;
            end
          end
        end

        ST_WR_ADDR: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if (w_byte_ev) begin
            RF_ADDR <= RX_P_DATA[ADDR_WIDTH-1:0];
            r_state <= ST_WR_DATA;
          end
        end

        ST_WR_DATA: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if (w_byte_ev) begin
            RF_WR_DATA <= RX_P_DATA;
            RF_WR_EN   <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end

        ST_RD_ADDR: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if (w_byte_ev) begin
            RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
            RF_RD_EN <= 1'b1;
            r_state  <= ST_RD_WAIT;
          end
        end

        // No timeout here: the register file is trusted to answer.
        ST_RD_WAIT: begin
          if (RF_RD_VLD) begin
            TX_P_DATA <= RF_RD_DATA;
            r_state   <= ST_TX_SEND;
          end
        end

        ST_TX_SEND: begin
          if (!TX_BUSY) begin
            TX_D_VLD <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Abort reporting: pulse plus saturating counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CMD_ERR <= 1'b0;
      ERR_CNT <= 8'd0;
    end else begin
      CMD_ERR <= w_abort;
      if (w_abort && (ERR_CNT != 8'hFF)) begin
        ERR_CNT <= ERR_CNT + 8'd1;
      end
    end
  end

endmodule : uart_rx_cmd_ctrl
`default_nettype wire

// File: tb/tb_uart_rx_cmd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_cmd_ctrl
// Description : Self-checking bench for uart_rx_cmd_ctrl. Stimulus tasks
//               send directed frames and, from the frame rules, schedule
//               the cycles on which each strobe, abort and register update
//               must appear. A compare process checks every DUT output
//               against that schedule on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cmd_ctrl;

  localparam int         c_T      = 1024;
  localparam logic [7:0] c_OP_WR  = 8'hAA;
  localparam logic [7:0] c_OP_RD  = 8'hBB;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic       RX_PAR_ERR = 1'b0;
  logic       RX_STP_ERR = 1'b0;
  logic       RF_WR_EN;
  logic       RF_RD_EN;
  logic [3:0] RF_ADDR;
  logic [7:0] RF_WR_DATA;
  logic [7:0] RF_RD_DATA = 8'h00;
  logic       RF_RD_VLD = 1'b0;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       TX_BUSY = 1'b0;
  logic       CMD_ERR;
  logic [7:0] ERR_CNT;

  uart_rx_cmd_ctrl #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (4),
    .TIMEOUT_CYC (c_T),
    .CMD_WR      (8'hAA),
    .CMD_RD      (8'hBB)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_P_DATA  (RX_P_DATA),
    .RX_D_VLD   (RX_D_VLD),
    .RX_PAR_ERR (RX_PAR_ERR),
    .RX_STP_ERR (RX_STP_ERR),
    .RF_WR_EN   (RF_WR_EN),
    .RF_RD_EN   (RF_RD_EN),
    .RF_ADDR    (RF_ADDR),
    .RF_WR_DATA (RF_WR_DATA),
    .RF_RD_DATA (RF_RD_DATA),
    .RF_RD_VLD  (RF_RD_VLD),
    .TX_P_DATA  (TX_P_DATA),
    .TX_D_VLD   (TX_D_VLD),
    .TX_BUSY    (TX_BUSY),
    .CMD_ERR    (CMD_ERR),
    .ERR_CNT    (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- expectation schedule (keyed by cycle) ----------------
  bit         ex_wr      [int];
  bit         ex_rd      [int];
  bit         ex_tx      [int];
  bit         ex_err     [int];
  logic [3:0] ex_addr_ch [int];
  logic [7:0] ex_wd_ch   [int];
  logic [7:0] ex_txd_ch  [int];

  logic [7:0] m_rf [16];     // expected register-file contents
  logic [3:0] m_addr = 4'h0;
  logic [7:0] m_wd   = 8'h00;
  logic [7:0] m_txd  = 8'h00;
  int         m_cnt  = 0;

  always @(negedge CLK) begin
    if (!RST) begin
      m_cnt  = 0;
      m_addr = 4'h0;
      m_wd   = 8'h00;
      m_txd  = 8'h00;
      chk("rst_strobes", {RF_WR_EN, RF_RD_EN, TX_D_VLD, CMD_ERR}, 0);
      chk("rst_err_cnt", ERR_CNT, 0);
    end else begin
      if (ex_addr_ch.exists(cyc)) m_addr = ex_addr_ch[cyc];
      if (ex_wd_ch.exists(cyc))   m_wd   = ex_wd_ch[cyc];
      if (ex_txd_ch.exists(cyc))  m_txd  = ex_txd_ch[cyc];
      if (ex_err.exists(cyc) && m_cnt < 255) m_cnt++;
      chk("rf_wr_en",   RF_WR_EN,   ex_wr.exists(cyc));
      chk("rf_rd_en",   RF_RD_EN,   ex_rd.exists(cyc));
      chk("tx_d_vld",   TX_D_VLD,   ex_tx.exists(cyc));
      chk("cmd_err",    CMD_ERR,    ex_err.exists(cyc));
      chk("err_cnt",    ERR_CNT,    m_cnt);
      chk("rf_addr",    RF_ADDR,    m_addr);
      chk("rf_wr_data", RF_WR_DATA, m_wd);
      chk("tx_p_data",  TX_P_DATA,  m_txd);
    end
  end

  // ---------------- register-file responder ----------------
  logic [7:0] env_rf [16];
  int         rd_due = -10;
  logic [7:0] rd_q   = 8'h00;

  always @(negedge CLK) begin
    if (RST && RF_WR_EN) env_rf[RF_ADDR] = RF_WR_DATA;
    if (RST && RF_RD_EN) begin
      rd_due = cyc + 2;
      rd_q   = env_rf[RF_ADDR];
    end
  end

  always @(posedge CLK) begin
    #1;
    RF_RD_VLD  = (cyc == rd_due);
    RF_RD_DATA = (cyc == rd_due) ? rd_q : 8'h00;
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Presents one byte during cycle k; the DUT samples it at the end of k.
  task automatic send(input logic [7:0] b, input bit par, input bit stp, output int k);
    @(posedge CLK);
    #1;
    RX_P_DATA  = b;
    RX_D_VLD   = 1'b1;
    RX_PAR_ERR = par;
    RX_STP_ERR = stp;
    k = cyc;
    @(posedge CLK);
    #1;
    RX_D_VLD   = 1'b0;
    RX_PAR_ERR = 1'b0;
    RX_STP_ERR = 1'b0;
  endtask

  task automatic wr_frame(input logic [7:0] a, input logic [7:0] d);
    int k;
    send(c_OP_WR, 1'b0, 1'b0, k);
    idle(8);
    send(a, 1'b0, 1'b0, k);
    if (a[7:4] != 4'h0) begin
      ex_err[k+1] = 1'b1;
      idle(2);
      return;
    end
    ex_addr_ch[k+1] = a[3:0];
    idle(8);
    send(d, 1'b0, 1'b0, k);
    ex_wr[k+1]    = 1'b1;
    ex_wd_ch[k+1] = d;
    m_rf[a[3:0]]  = d;
    idle(2);
  endtask

  // inj: 0 none, 1 parity-error byte while waiting on the register file,
  //      2 clean byte while waiting on the transmitter.
  task automatic rd_frame(input logic [7:0] a, input int busy, input int inj);
    int k, rel, tx_c, inj_c;
    TX_BUSY = (busy > 0);
    send(c_OP_RD, 1'b0, 1'b0, k);
    idle(8);
    send(a, 1'b0, 1'b0, k);
    if (a[7:4] != 4'h0) begin
      ex_err[k+1] = 1'b1;
      TX_BUSY = 1'b0;
      idle(2);
      return;
    end
    // Read strobe at k+1, data valid at k+3, TX data visible at k+4.
    ex_addr_ch[k+1] = a[3:0];
    ex_rd[k+1]      = 1'b1;
    ex_txd_ch[k+4]  = m_rf[a[3:0]];
    rel   = (busy > 0) ? k + busy : k + 1;
    tx_c  = ((rel > k + 4) ? rel : k + 4) + 1;
    ex_tx[tx_c] = 1'b1;
    inj_c = (inj == 1) ? k + 2 : ((inj == 2) ? k + 6 : -1);
    if (inj_c > 0) ex_err[inj_c+1] = 1'b1;
    for (int c = k + 1; c <= tx_c + 1; c++) begin
      TX_BUSY    = (c < rel);
      RX_D_VLD   = (c == inj_c);
      RX_P_DATA  = 8'h55;
      RX_PAR_ERR = (c == inj_c) && (inj == 1);
      @(posedge CLK);
      #1;
    end
    RX_D_VLD   = 1'b0;
    RX_PAR_ERR = 1'b0;
    TX_BUSY    = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst_strobes", {RF_WR_EN, RF_RD_EN, TX_D_VLD, CMD_ERR}, 0);
    chk("async_rst_addr",    RF_ADDR,    0);
    chk("async_rst_wdata",   RF_WR_DATA, 0);
    chk("async_rst_txdata",  TX_P_DATA,  0);
    chk("async_rst_errcnt",  ERR_CNT,    0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    for (int i = 0; i < 16; i++) begin
      m_rf[i]   = 8'h00;
      env_rf[i] = 8'h00;
    end
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_rf_wr_en", RF_WR_EN, 0);
    chk("reset_err_cnt",  ERR_CNT,  0);
    RST = 1'b1;
    idle(2);

    // Write AA,05,3C
    wr_frame(8'h05, 8'h3C);
    chk("lit_wr_addr",  RF_ADDR,    5);
    chk("lit_wr_data",  RF_WR_DATA, 8'h3C);
    chk("lit_wr_noerr", ERR_CNT,    0);

    // Read BB,05 with transmitter busy for 20 cycles
    rd_frame(8'h05, 20, 0);
    chk("lit_tx_data", TX_P_DATA, 8'h3C);

    // Parity error on the address byte (with RX_D_VLD also high)
    send(c_OP_WR, 1'b0, 1'b0, k);
    idle(8);
    send(8'h02, 1'b1, 1'b0, k);
    ex_err[k+1] = 1'b1;
    idle(3);
    chk("lit_par_errcnt", ERR_CNT, 1);
    chk("lit_par_addr_kept", RF_ADDR, 5);
    wr_frame(8'h02, 8'h11);

    // Reads with an error while waiting and a dropped byte while sending
    rd_frame(8'h02, 20, 1);
    rd_frame(8'h02, 20, 2);
    rd_frame(8'h05, 0, 0);

    // Stop-bit error on the data byte: no write, data register kept
    send(c_OP_WR, 1'b0, 1'b0, k);
    idle(8);
    send(8'h03, 1'b0, 1'b0, k);
    ex_addr_ch[k+1] = 4'h3;
    idle(8);
    send(8'h44, 1'b0, 1'b1, k);
    ex_err[k+1] = 1'b1;
    idle(3);
    chk("lit_stp_wdata_kept", RF_WR_DATA, 8'h11);

    // Timeout in WR_DATA from a fresh reset, then a stray byte in IDLE
    pulse_reset();
    send(c_OP_WR, 1'b0, 1'b0, k);
    idle(8);
    send(8'h05, 1'b0, 1'b0, k);
    ex_addr_ch[k+1] = 4'h5;
    ex_err[k+c_T]   = 1'b1;
    idle(c_T + 2);
    chk("lit_tmo_errcnt", ERR_CNT, 1);
    send(8'h11, 1'b0, 1'b0, k);
    ex_err[k+1] = 1'b1;
    idle(3);
    chk("lit_tmo_errcnt2", ERR_CNT, 2);

    // Address range and unknown opcode
    wr_frame(8'h15, 8'h99);
    rd_frame(8'h1F, 0, 0);
    send(8'h7A, 1'b0, 1'b0, k);
    ex_err[k+1] = 1'b1;
    idle(3);
    chk("lit_range_errcnt", ERR_CNT, 5);

    // 260 more aborts: counter saturates
    for (int i = 0; i < 260; i++) begin
      send(8'h7A, 1'b0, 1'b0, k);
      ex_err[k+1] = 1'b1;
    end
    idle(3);
    chk("lit_sat_errcnt", ERR_CNT, 255);

    // Reset in the middle of WR_DATA, then a clean write
    send(c_OP_WR, 1'b0, 1'b0, k);
    idle(8);
    send(8'h07, 1'b0, 1'b0, k);
    ex_addr_ch[k+1] = 4'h7;
    idle(3);
    chk("lit_pre_rst_addr", RF_ADDR, 7);
    pulse_reset();
    wr_frame(8'h01, 8'hFF);
    chk("lit_post_rst_addr",  RF_ADDR,    1);
    chk("lit_post_rst_wdata", RF_WR_DATA, 8'hFF);
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_cmd_ctrl
`default_nettype wire

// File: doc/uart_rx_cmd_ctrl.md
Name: uart_rx_cmd_ctrl

Overview:
Command-frame controller sitting behind the UART receiver. It consumes received bytes (with parity/stop error flags) and decodes register-file write and read frames. It sequences register-file accesses and returns read data to the UART transmitter through a busy/valid handshake. It is the system-control point between the serial link and the register file.

Parameters:
DATA_WIDTH, 8, width of UART bytes, register data and TX data
ADDR_WIDTH, 4, register-file address width; address byte bits above ADDR_WIDTH must be 0
TIMEOUT_CYC, 1024, max CLK cycles allowed between consecutive bytes of one frame
CMD_WR, 8'hAA, write command opcode
CMD_RD, 8'hBB, read command opcode

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-low
RX_P_DATA  in  DATA_WIDTH  received byte
RX_D_VLD  in  1  one-cycle pulse: RX_P_DATA valid
RX_PAR_ERR  in  1  one-cycle pulse: parity error on current byte
RX_STP_ERR  in  1  one-cycle pulse: stop-bit error on current byte
RF_WR_EN  out  1  one-cycle register write strobe
RF_RD_EN  out  1  one-cycle register read strobe
RF_ADDR  out  ADDR_WIDTH  register address
RF_WR_DATA  out  DATA_WIDTH  register write data
RF_RD_DATA  in  DATA_WIDTH  register read data
RF_RD_VLD  in  1  RF_RD_DATA valid, pulse
TX_P_DATA  out  DATA_WIDTH  byte to transmit
TX_D_VLD  out  1  one-cycle transmit request
TX_BUSY  in  1  transmitter busy
CMD_ERR  out  1  one-cycle pulse on any frame abort
ERR_CNT  out  8  saturating count of aborts

Behaviour:
- Reset (RST=0, async): state IDLE; all outputs 0; timeout counter 0; ERR_CNT 0. Reset mid-frame discards the frame with no RF/TX strobe.
- Byte event = RX_D_VLD & ~RX_PAR_ERR & ~RX_STP_ERR. Error event = RX_PAR_ERR | RX_STP_ERR. If both occur in the same cycle, the error takes priority.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE:
  - byte==CMD_WR -> WR_ADDR.
  - byte==CMD_RD -> RD_ADDR.
  - Any other byte -> abort, stay in IDLE.
  - Error event -> abort.
- WR_ADDR: byte -> latch RF_ADDR=byte[ADDR_WIDTH-1:0] -> WR_DATA. If upper bits are nonzero -> abort.
- WR_DATA: byte -> RF_WR_DATA=byte, RF_WR_EN=1 for exactly one cycle (registered, the cycle after the byte) -> IDLE.
- RD_ADDR: byte -> latch RF_ADDR (same range check), RF_RD_EN=1 for one cycle -> RD_WAIT.
- RD_WAIT: on RF_RD_VLD, latch TX_P_DATA=RF_RD_DATA -> TX_SEND.
- TX_SEND: first cycle with TX_BUSY=0 -> TX_D_VLD=1 for one cycle -> IDLE. TX_P_DATA holds until the next read completes.
- Bytes arriving in RD_WAIT/TX_SEND are dropped and counted as aborts; the state does not change.
- Timeout: in WR_ADDR/WR_DATA/RD_ADDR the counter increments each cycle and clears on any byte/error event. Reaching TIMEOUT_CYC-1 -> abort.
- Abort: CMD_ERR=1 for one cycle; ERR_CNT+1, saturating at 255; state -> IDLE (except the RD_WAIT/TX_SEND drop case above). RF_ADDR and RF_WR_DATA keep their last values.
- Error event in RD_WAIT/TX_SEND: counted as an abort; the read still completes.
- RF strobes are never asserted together; at most one frame is in flight at a time.

Decomposition:
- Shared package (uart_sys_pkg): FSM state encoding (one-hot, 6 states), CMD_WR/CMD_RD opcodes, DATA_WIDTH/ADDR_WIDTH defaults.
- One natural sub-module: uart_frame_timeout (counter with clear/enable, expire pulse at TIMEOUT_CYC-1).
- Rest is a single FSM plus datapath registers.

Test Plan:
- Write frame AA,05,3C (byte pulses 10 cycles apart) -> one-cycle RF_WR_EN with RF_ADDR=5, RF_WR_DATA=0x3C, one cycle after byte 3; CMD_ERR stays 0.
- Read frame BB,05; RF returns 0x3C with RF_RD_VLD 2 cycles after RF_RD_EN; TX_BUSY=1 for 20 cycles -> TX_D_VLD pulses on first TX_BUSY=0 cycle with TX_P_DATA=0x3C.
- Frame AA, then 02 with RX_PAR_ERR=1 -> CMD_ERR pulse, ERR_CNT=1, no RF_WR_EN; following AA,02,11 writes normally.
- Frame AA,05 then silence TIMEOUT_CYC cycles -> CMD_ERR at cycle TIMEOUT_CYC-1 after byte 2, state IDLE; next byte 11 in IDLE -> second abort, ERR_CNT=2.
- Address range: AA,15 (ADDR_WIDTH=4) -> abort, no write. Unknown opcode 0x7A -> abort. 260 aborts -> ERR_CNT saturates at 255.
- RST low mid-WR_DATA -> all outputs 0 immediately (async); after release, AA,01,FF completes with RF_WR_EN.
